// File: rtl/piezo_melody_player.sv
// piezo_melody_player
//   Plays one of four fixed 4-note melodies on a piezo pin. Each note is a
//   square wave (period 2*H clocks, H from a half-period table) held for
//   NOTE_CYC clocks, then GAP_CYC silent clocks. A half-period of 0 is a rest.
// Ports
//   clk_1mhz  in   system clock
//   rst_n     in   synchronous active-low reset
//   start     in   request playback (accepted only in IDLE)
//   sel[1:0]  in   melody select, latched on accepted start
//   abort     in   stop playback at once, no done pulse
//   busy      out  high while a note or gap is playing
//   done      out  one-cycle pulse after the last note/gap
//   note_idx  out  note currently playing (0..3)
//   piezo     out  square-wave drive
module piezo_melody_player #(
  parameter int NOTE_CYC = 250_000,
  parameter int GAP_CYC  = 50_000,
  parameter int DUR_W    = 18,
  parameter int HALF_W   = 11
) (
  input  logic       clk_1mhz,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [1:0] note_idx,
  output logic       piezo
);

  typedef enum logic [1:0] {IDLE, TONE, GAP, DONE} state_t;

  localparam bit HAS_GAP  = (GAP_CYC > 0);
  localparam int GAP_LAST = HAS_GAP ? GAP_CYC - 1 : 0;

  localparam logic [DUR_W-1:0]  NOTE_END = DUR_W'(NOTE_CYC - 1);
  localparam logic [DUR_W-1:0]  GAP_END  = DUR_W'(GAP_LAST);

  localparam logic [HALF_W-1:0] H_DO   = HALF_W'(1911);
  localparam logic [HALF_W-1:0] H_RE   = HALF_W'(1703);
  localparam logic [HALF_W-1:0] H_MI   = HALF_W'(1517);
  localparam logic [HALF_W-1:0] H_FA   = HALF_W'(1432);
  localparam logic [HALF_W-1:0] H_SOL  = HALF_W'(1276);
  localparam logic [HALF_W-1:0] H_LA   = HALF_W'(1136);
  localparam logic [HALF_W-1:0] H_DO2  = HALF_W'(956);
  localparam logic [HALF_W-1:0] H_REST = '0;

  // Melody ROM: half-period of note idx of melody msel.
  function automatic logic [HALF_W-1:0] half_lut(input logic [1:0] msel,
                                                 input logic [1:0] idx);
    logic [HALF_W-1:0] h;
    h = H_REST;
    case ({msel, idx})
      4'b00_00: h = H_DO;   // pass
      4'b00_01: h = H_MI;
      4'b00_10: h = H_SOL;
      4'b00_11: h = H_DO2;
      4'b01_00: h = H_SOL;  // fail
      4'b01_01: h = H_MI;
      4'b01_10: h = H_DO;
      4'b01_11: h = H_REST;
      4'b10_00: h = H_DO;   // boot
      4'b10_01: h = H_RE;
      4'b10_10: h = H_MI;
      4'b10_11: h = H_FA;
      4'b11_00: h = H_LA;   // alert
      4'b11_01: h = H_REST;
      4'b11_10: h = H_LA;
      4'b11_11: h = H_REST;
      default:  h = H_REST;
    endcase
    return h;
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          idx_q, idx_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic                piezo_q, piezo_d;
  logic [HALF_W-1:0]   h_cur;

  assign h_cur = half_lut(sel_q, idx_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    half_d  = half_q;
    piezo_d = piezo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = sel;
          idx_d   = 2'd0;
          dur_d   = '0;
          half_d  = '0;
          piezo_d = 1'b0;
          state_d = TONE;
        end
      end
      TONE: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          dur_d   = '0;
          half_d  = '0;
          piezo_d = 1'b0;
        end else if (dur_q == NOTE_END) begin
          // Note over: silence and clear counters; the next TONE entry
          // therefore always starts in phase 0 with piezo low.
          dur_d   = '0;
          half_d  = '0;
          piezo_d = 1'b0;
          if (HAS_GAP)           state_d = GAP;
          else if (idx_q == 2'd3) state_d = DONE;
          else                   idx_d   = idx_q + 2'd1;
        end else begin
          dur_d = dur_q + 1'b1;
          if (h_cur != H_REST) begin
            if (half_q == h_cur - 1'b1) begin
              half_d  = '0;
              piezo_d = ~piezo_q;
            end else begin
              half_d = half_q + 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          dur_d   = '0;
          half_d  = '0;
          piezo_d = 1'b0;
        end else if (dur_q == GAP_END) begin
          dur_d = '0;
          if (idx_q == 2'd3) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = TONE;
          end
        end else begin
          dur_d = dur_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1mhz) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      idx_q   <= 2'd0;
      dur_q   <= '0;
      half_q  <= '0;
      piezo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      half_q  <= half_d;
      piezo_q <= piezo_d;
    end
  end

  // All outputs come straight from flops: no input-to-output paths.
  assign busy     = (state_q == TONE) || (state_q == GAP);
  assign done     = (state_q == DONE);
  assign note_idx = idx_q;
  assign piezo    = piezo_q;

endmodule
